// File: rtl/ctrl_unit_pkg.sv
// rtl/ctrl_unit_pkg.sv - shared constants, state encoding and field helpers for ctrl_unit
package ctrl_unit_pkg;

  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_OP_WIDTH    = 2;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_INSTR_WIDTH = 8;

  localparam int OPC_BITS = 4;
  localparam int OPD_BITS = 4;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_ADDI = 4'h2;
  localparam logic [3:0] OPC_INC  = 4'h3;
  localparam logic [3:0] OPC_JMP  = 4'h4;
  localparam logic [3:0] OPC_JZ   = 4'h5;
  localparam logic [3:0] OPC_OUT  = 4'h6;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [1:0] ALU_SUM = 2'b00;
  localparam logic [1:0] ALU_IN0 = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_IN1 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic [OPC_BITS-1:0] opcode_of(input logic [DEF_INSTR_WIDTH-1:0] instr);
    return instr[DEF_INSTR_WIDTH-1 -: OPC_BITS];
  endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// rtl/ctrl_unit_if.sv - program ROM and ALU bus between the sequencer and its neighbours
interface ctrl_unit_if
  import ctrl_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OP_WIDTH    = DEF_OP_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);
  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0]  alu_in0;
  logic [DATA_WIDTH-1:0]  alu_in1;
  logic [OP_WIDTH-1:0]    alu_op;
  logic [DATA_WIDTH-1:0]  alu_out;

  modport master (output pc, alu_in0, alu_in1, alu_op, input instr, alu_out);
  modport slave  (input pc, alu_in0, alu_in1, alu_op, output instr, alu_out);
endinterface

// File: rtl/ctrl_unit_prog_counter.sv
// rtl/ctrl_unit_prog_counter.sv - program counter with load priority over increment
module prog_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (inc)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - fetch/decode/writeback sequencer around the external 4-bit ALU
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OP_WIDTH    = DEF_OP_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  ctrl_unit_if.master           bus,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  halted,
  output logic                  illegal
);

  state_t                 state, state_next;
  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]  acc;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [OPC_BITS-1:0]    opc;
  logic [OP_WIDTH-1:0]    alu_op;
  logic                   pc_inc, pc_load, acc_we, out_we, illegal_next;

  assign opc         = opcode_of(ir);
  assign bus.pc      = pc;
  assign bus.alu_in0 = acc;
  assign bus.alu_in1 = ir[DATA_WIDTH-1:0];
  assign bus.alu_op  = alu_op;
  assign halted      = (state == ST_HALT);

  prog_counter #(.WIDTH(ADDR_WIDTH)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .inc        (pc_inc),
    .load       (pc_load),
    .load_value (ir[ADDR_WIDTH-1:0]),
    .count      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ir        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= out_we;
      illegal   <= illegal_next;
      if (state == ST_FETCH)
        ir <= bus.instr;
      if (acc_we)
        acc <= bus.alu_out;
      if (out_we)
        out_data <= acc;
    end
  end

  // Non-ALU opcodes and non-EXEC states pass IN0 so the ALU output mirrors ACC.
  always_comb begin
    state_next   = state;
    alu_op       = ALU_IN0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    acc_we       = 1'b0;
    out_we       = 1'b0;
    illegal_next = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        pc_inc     = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        case (opc)
          OPC_NOP:  ;
          OPC_LDI:  begin alu_op = ALU_IN1; acc_we = 1'b1; end
          OPC_ADDI: begin alu_op = ALU_SUM; acc_we = 1'b1; end
          OPC_INC:  begin alu_op = ALU_INC; acc_we = 1'b1; end
          OPC_JMP:  pc_load = 1'b1;
          OPC_JZ:   pc_load = (acc == '0);
          OPC_OUT:  out_we = 1'b1;
          OPC_HALT: state_next = ST_HALT;
          default:  illegal_next = 1'b1;
        endcase
      end
      ST_HALT:  ;
      default:  state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
Single-accumulator sequencer that feeds the 4-bit ALU and consumes its result.
- Fetches 8-bit instructions from an external combinational program ROM.
- Decodes each instruction into the ALU operation code and operands (IN0 = accumulator, IN1 = immediate), then writes the ALU result back into the accumulator.
- Also handles jumps, output latching and halt. It is the fetch/decode/writeback wrapper around the ALU in the microprocessor top level.

Parameters:
- DATA_WIDTH, 4, ALU operand/accumulator width.
- OP_WIDTH, 2, ALU opcode width.
- ADDR_WIDTH, 4, program counter width (must be <= DATA_WIDTH; jump target = low ADDR_WIDTH bits of the operand).
- INSTR_WIDTH, 8, instruction width: [7:4] opcode, [3:0] operand.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level-sampled in IDLE; begins execution from PC=0.
- PC  out  ADDR_WIDTH  program ROM address.
- INSTR  in  INSTR_WIDTH  ROM data for PC (combinational ROM, valid same cycle).
- ALU_IN0  out  DATA_WIDTH  always = ACC.
- ALU_IN1  out  DATA_WIDTH  always = IR[3:0].
- ALU_OP  out  OP_WIDTH  ALU operation (see Behaviour).
- ALU_OUT  in  DATA_WIDTH  ALU result (combinational from ALU_IN0/1/OP).
- OUT_DATA  out  DATA_WIDTH  last value emitted by OUT instruction.
- OUT_VALID  out  1  one-cycle pulse when OUT_DATA updates.
- HALTED  out  1  high in HALT state.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (sync, RST=1 at edge, any state, incl. mid-instruction):
  - State=IDLE; PC=0, IR=0, ACC=0, OUT_DATA=0.
  - OUT_VALID=0, ILLEGAL=0, HALTED=0; pending writes discarded.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: START=1 -> FETCH. START is ignored in every other state.
- FETCH (1 cycle): IR<=INSTR, PC<=PC+1 (mod 2^ADDR_WIDTH, 4'hF -> 4'h0) -> EXEC.
- EXEC (1 cycle): ALU_OP is driven from IR; at the edge, the opcode takes effect as below, then -> FETCH (except HALT).
  - 0x0 NOP: nothing.
  - 0x1 LDI: ALU_OP=2'b11 (pass IN1); ACC<=ALU_OUT.
  - 0x2 ADDI: ALU_OP=2'b00 (SUM); ACC<=ALU_OUT, wraps mod 16; no carry is kept.
  - 0x3 INC: ALU_OP=2'b10; ACC<=ALU_OUT (4'hF -> 4'h0).
  - 0x4 JMP: PC<=IR[3:0]; overrides the increment already done in FETCH.
  - 0x5 JZ: if ACC==0, PC<=IR[3:0]; else PC is unchanged.
  - 0x6 OUT: OUT_DATA<=ACC; OUT_VALID=1 for the following cycle only.
  - 0xF HALT: -> HALT.
  - 0x7-0xE: treated as NOP; ILLEGAL=1 for the following cycle only.
- ALU_OP outside EXEC, and for non-ALU opcodes: 2'b01 (pass IN0), so ALU_OUT=ACC.
- HALT: HALTED=1. PC, ACC and OUT_DATA are frozen; only RST leaves this state.
- Throughput: 2 cycles per instruction; jumps take effect on the next FETCH with no extra bubble.
- ACC is written only in EXEC and only by LDI/ADDI/INC.
- OUT_VALID and ILLEGAL are registered and never high in the same cycle.
- JZ tests ACC as it is at the start of EXEC.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OPC_NOP..OPC_HALT;
  - ALU op constants ALU_SUM=2'b00, ALU_IN0=2'b01, ALU_INC=2'b10, ALU_IN1=2'b11;
  - state encoding;
  - instruction field positions.
- One sub-module: prog_counter (increment, load, sync reset).
- The FSM, decode and ACC live in ctrl_unit. The ALU is instantiated at top level, not inside this block.

Test Plan:
- Reset then START=1, ROM {0:LDI 5, 1:ADDI 3, 2:OUT, 3:HALT} -> OUT_VALID pulse with OUT_DATA=8; HALTED=1 after 8 cycles; PC=4.
- ROM {0:LDI F, 1:INC, 2:OUT, 3:JZ 6, 6:ADDI 9, 7:OUT, 8:HALT} -> first OUT_DATA=0 (wrap), JZ taken, second OUT_DATA=9.
- PC wrap: ROM 0..E = NOP, F = JMP 2 -> PC sequence ...E, F, 0 (after FETCH), then 2; no stall.
- ROM {0:opcode 0x9, 1:HALT} -> ILLEGAL pulses once for exactly 1 cycle; ACC stays 0; HALTED=1.
- Assert RST during EXEC of ADDI 7 with ACC=3 -> next cycle ACC=0, PC=0, state IDLE, no OUT_VALID; START is ignored while HALTED=1 until RST.
